adder_seq_arbiter: RTL and testbench

//  Shares one 32-bit adder slice between two requesters and sequences it

---
 rtl/adder_pkg.sv | 21 ++
 rtl/adder32.sv | 22 ++
 rtl/adder_seq_arbiter.sv | 144 ++++++++++++++
 tb/tb_adder_seq_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg: shared slice width, FSM state and op encodings -- Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package adder_pkg;

  localparam int W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/adder32.sv
// ----------------------------------------------------------------------------
// adder32: combinational W-bit adder slice with carry in/out -- Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module adder32
  import adder_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

`default_nettype wire

// File: rtl/adder_seq_arbiter.sv
// ----------------------------------------------------------------------------
// adder_seq_arbiter: round-robin shared adder, word-serial multi-word add/sub
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module adder_seq_arbiter
  import adder_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int WORDS = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WORDS*W-1:0]   req0_a,
  input  logic [WORDS*W-1:0]   req0_b,
  input  logic                 req0_sub,
  input  logic                 req0_cin,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WORDS*W-1:0]   req1_a,
  input  logic [WORDS*W-1:0]   req1_b,
  input  logic                 req1_sub,
  input  logic                 req1_cin,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_id,
  output logic [WORDS*W-1:0]   res_data,
  output logic                 res_cout,
  output logic                 res_ovf
);

  localparam int N  = WORDS * W;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_t          state;
  state_t          state_nx;
  logic [IW-1:0]   idx;
  logic            carry;
  logic            last_grant;
  logic [N-1:0]    op_a;
  logic [N-1:0]    op_b;

  logic            grant0;
  logic            grant1;
  logic            accept;
  logic            sel_id;
  logic [N-1:0]    sel_a;
  logic [N-1:0]    sel_b;
  logic            sel_sub;
  logic            sel_cin;
  logic [W-1:0]    a_word;
  logic [W-1:0]    b_word;
  logic [W-1:0]    s_word;
  logic            c_word;
  logic            last_word;

  // Contention goes to whichever requester was not served last
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant);
    grant1 = req1_valid && (!req0_valid || !last_grant);
  end

  assign req0_ready = (state == ST_IDLE) && grant0;
  assign req1_ready = (state == ST_IDLE) && grant1;
  assign accept     = req0_ready || req1_ready;
  assign sel_id     = req1_ready;

  assign sel_a   = sel_id ? req1_a   : req0_a;
  assign sel_b   = sel_id ? req1_b   : req0_b;
  assign sel_sub = sel_id ? req1_sub : req0_sub;
  assign sel_cin = sel_id ? req1_cin : req0_cin;

  assign a_word    = op_a[int'(idx)*W +: W];
  assign b_word    = op_b[int'(idx)*W +: W];
  assign last_word = (idx == LAST_IDX);

  adder32 #(.W(W)) u_adder (
    .a    (a_word),
    .b    (b_word),
    .cin  (carry),
    .s    (s_word),
    .cout (c_word)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept)    state_nx = ST_RUN;
      ST_RUN:  if (last_word) state_nx = ST_DONE;
      ST_DONE: if (res_ready) state_nx = ST_IDLE;
      default:                state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx        <= '0;
      carry      <= 1'b0;
      last_grant <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      res_valid  <= 1'b0;
      res_id     <= 1'b0;
      res_data   <= '0;
      res_cout   <= 1'b0;
      res_ovf    <= 1'b0;
    end else begin
      if (accept) begin
        // Subtraction is A + ~B + ~borrow, so the slice only ever adds
        op_a       <= sel_a;
        op_b       <= (sel_sub == OP_SUB) ? ~sel_b : sel_b;
        carry      <= (sel_sub == OP_SUB) ? ~sel_cin : sel_cin;
        idx        <= '0;
        last_grant <= sel_id;
        res_id     <= sel_id;
      end
      if (state == ST_RUN) begin
        res_data[int'(idx)*W +: W] <= s_word;
        carry                      <= c_word;
        if (last_word) begin
          idx       <= '0;
          res_valid <= 1'b1;
          res_cout  <= c_word;
          res_ovf   <= (a_word[W-1] == b_word[W-1]) && (s_word[W-1] != a_word[W-1]);
        end else begin
          idx <= idx + 1'b1;
        end
      end
      if ((state == ST_DONE) && res_ready) res_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adder_seq_arbiter.sv
// ----------------------------------------------------------------------------
// tb_adder_seq_arbiter: scoreboard bench with full-width arithmetic reference
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_adder_seq_arbiter;

  localparam int W     = 32;
  localparam int WORDS = 2;
  localparam int N     = W * WORDS;

  typedef struct {
    logic         id;
    logic [N-1:0] data;
    logic         cout;
    logic         ovf;
    int           acc_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         resetn;
  logic         req0_valid, req0_ready, req0_sub, req0_cin;
  logic         req1_valid, req1_ready, req1_sub, req1_cin;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         res_valid, res_ready, res_id, res_cout, res_ovf;
  logic [N-1:0] res_data;

  exp_t exp_q[$];
  bit   acc_ids[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_count = 0;
  bit   acc_flag0 = 0, acc_flag1 = 0;
  bit   busy = 0, last = 1;
  bit   prev_valid = 0, prev_taken = 0;

  adder_seq_arbiter #(.W(W), .WORDS(WORDS)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sub(req0_sub), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sub(req1_sub), .req1_cin(req1_cin),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_data(res_data),
    .res_cout(res_cout), .res_ovf(res_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: whole-operand arithmetic, signed overflow from operand/result signs
  task automatic ref_model(input logic [N-1:0] a, b, input logic sub, cin,
                           output logic [N-1:0] data, output logic cout, ovf);
    logic [N:0] full;
    if (!sub) begin
      full = {1'b0, a} + {1'b0, b} + (N+1)'(cin);
      cout = full[N];
      ovf  = (a[N-1] == b[N-1]) && (full[N-1] != a[N-1]);
    end else begin
      full = {1'b0, a} - {1'b0, b} - (N+1)'(cin);
      cout = !full[N];
      ovf  = (a[N-1] != b[N-1]) && (full[N-1] != a[N-1]);
    end
    data = full[N-1:0];
  endtask

  // Issue side: predicts grants, pushes expected results at each accept
  always @(negedge clk) begin
    bit g0, g1, e0, e1;
    exp_t e;
    acc_flag0 = 0;
    acc_flag1 = 0;
    if (!resetn) begin
      exp_q.delete();
      busy = 0;
      last = 1;
    end else begin
      g0 = req0_valid && (!req1_valid || last);
      g1 = req1_valid && (!req0_valid || !last);
      e0 = !busy && g0;
      e1 = !busy && g1;
      check("req0_ready", N'(req0_ready), N'(e0));
      check("req1_ready", N'(req1_ready), N'(e1));
      if (e0 || e1) begin
        e.id = e1;
        if (e1) ref_model(req1_a, req1_b, req1_sub, req1_cin, e.data, e.cout, e.ovf);
        else    ref_model(req0_a, req0_b, req0_sub, req0_cin, e.data, e.cout, e.ovf);
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        acc_ids.push_back(e1);
        busy = 1;
        last = e1;
        acc_count++;
        acc_flag0 = e0;
        acc_flag1 = e1;
      end else if (busy && res_valid && res_ready) begin
        busy = 0;
      end
    end
  end

  // Monitor: compares every presented result against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      check("res_valid_in_reset", N'(res_valid), '0);
      prev_valid = 0;
      prev_taken = 0;
    end else begin
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          check("stale_result", N'(res_valid), '0);
        end else begin
          e = exp_q[0];
          if (!prev_valid || prev_taken) check("latency", N'(cyc - e.acc_cyc), N'(WORDS + 1));
          check("res_id",   N'(res_id),   N'(e.id));
          check("res_data", res_data,     e.data);
          check("res_cout", N'(res_cout), N'(e.cout));
          check("res_ovf",  N'(res_ovf),  N'(e.ovf));
          if (res_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid = res_valid;
      prev_taken = res_valid && res_ready;
    end
  end

  function automatic logic [N-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(N-1){1'b1}}};
      3:       return {1'b1, {(N-1){1'b0}}};
      4:       return {{W{1'b0}}, {W{1'b1}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic rand_req(input bit which);
    if (!which) begin
      req0_a = pick(); req0_b = pick(); req0_sub = 1'($urandom); req0_cin = 1'($urandom);
    end else begin
      req1_a = pick(); req1_b = pick(); req1_sub = 1'($urandom); req1_cin = 1'($urandom);
    end
  endtask

  // Holds valids until nops more accepts; rnd also drops valids and stalls res_ready
  task automatic run_ops(input bit use0, use1, input int nops, input bit init, input bit rnd);
    int target = acc_count + nops;
    int guard  = 0;
    if (init) begin rand_req(0); rand_req(1); end
    req0_valid = use0;
    req1_valid = use1;
    while (acc_count < target && guard < 100 * nops + 100) begin
      @(posedge clk); #1;
      guard++;
      if (acc_count >= target) break;
      if (acc_flag0) rand_req(0);
      if (acc_flag1) rand_req(1);
      if (rnd) begin
        req0_valid = use0 && ($urandom_range(0, 3) != 0);
        req1_valid = use1 && ($urandom_range(0, 3) != 0);
        res_ready  = ($urandom_range(0, 3) != 0);
      end
    end
    req0_valid = 0;
    req1_valid = 0;
    if (acc_count < target) check("accept_timeout", N'(acc_count), N'(target));
  endtask

  task automatic wait_drain();
    int g = 0;
    res_ready = 1;
    while ((exp_q.size() != 0 || res_valid) && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 200) check("drain_timeout", N'(exp_q.size()), '0);
  endtask

  initial begin
    int start;
    int g;
    resetn = 0; res_ready = 1;
    req0_valid = 0; req1_valid = 0;
    req0_a = '0; req0_b = '0; req0_sub = 0; req0_cin = 0;
    req1_a = '0; req1_b = '0; req1_sub = 0; req1_cin = 0;
    repeat (3) @(posedge clk); #1;
    check("rst_res_data", res_data, '0);
    check("rst_res_id",   N'(res_id), '0);
    check("rst_res_cout", N'(res_cout), '0);
    check("rst_res_ovf",  N'(res_ovf), '0);
    resetn = 1;
    @(posedge clk); #1;

    // Carry across the word boundary
    req0_a = 64'h0000_0000_FFFF_FFFF; req0_b = 64'd1; req0_sub = 0; req0_cin = 0;
    run_ops(1, 0, 1, 0, 0);
    wait_drain();
    // Signed overflow into the sign bit
    req0_a = 64'h7FFF_FFFF_FFFF_FFFF; req0_b = 64'd1; req0_sub = 0; req0_cin = 0;
    run_ops(1, 0, 1, 0, 0);
    wait_drain();
    // Borrow through every word
    req1_a = 64'd0; req1_b = 64'd1; req1_sub = 1; req1_cin = 0;
    run_ops(0, 1, 1, 0, 0);
    wait_drain();

    // Continuous contention alternates grants starting with req0
    start = acc_ids.size();
    run_ops(1, 1, 4, 1, 0);
    wait_drain();
    for (int i = 0; i < 4; i++) check("rr_order", N'(acc_ids[start + i]), N'(i % 2));

    // Consumer stall: result must hold, no new accepts
    res_ready = 0;
    run_ops(1, 0, 1, 1, 0);
    res_ready = 0;
    g = 0;
    while (!res_valid && g < 20) begin @(posedge clk); #1; g++; end
    check("stall_res_valid", N'(res_valid), N'(1));
    req0_valid = 1; req1_valid = 1;
    repeat (5) begin @(posedge clk); #1; end
    res_ready = 1;
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    wait_drain();

    // Reset mid-operation discards it and restores req0 priority
    run_ops(1, 0, 1, 1, 0);
    resetn = 0;
    #1;
    check("reset_res_valid", N'(res_valid), '0);
    repeat (2) @(posedge clk); #1;
    resetn = 1;
    @(posedge clk); #1;
    start = acc_ids.size();
    run_ops(1, 1, 1, 1, 0);
    if (acc_ids.size() > start) check("post_reset_grant", N'(acc_ids[start]), '0);
    else                        check("post_reset_accept", N'(acc_ids.size()), N'(start + 1));
    wait_drain();

    // Randomized traffic with valid drops and consumer back-pressure
    run_ops(1, 1, 40, 1, 1);
    run_ops(1, 0, 10, 1, 1);
    run_ops(0, 1, 10, 1, 1);
    wait_drain();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
